pwm_bank: RTL and testbench
===========================

PWM_BANK -- requirements
Module: pwm_bank

Interface
REQ-001 Parameter CH, default 2: number of independent PWM channels, 1..16.
REQ-002 Parameter W, default 8: width of the period, duty and counter fields, 2..16.
REQ-003 clk  input  1: single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1: reset, synchronous, active-low.
REQ-005 sin  input  1: serial configuration data.
REQ-006 sin_vld  input  1: when high, sin is shifted in this cycle.
REQ-007 st_clk  input  1: load strobe; copies the shift register into the shadow registers.
REQ-008 sout  output  1: MSB of the shift register, for daisy-chaining.
REQ-009 pwm_out  output  CH: per-channel PWM output, registered.
REQ-010 upd_pend  output  CH: per-channel flag; the shadow holds values not yet applied.

Function
REQ-011 Shift register sr is N=CH*2*W bits; when sin_vld=1, sr <= {sr[N-2:0], sin}; otherwise sr holds.
REQ-012 sout SHALL equal sr[N-1] combinationally from the register, with no extra delay.
REQ-013 Channel k fields:
- duty = sr[2W*k+2W-1 : 2W*k+W]
- period = sr[2W*k+W-1 : 2W*k]
- Frame order, MSB first: ch CH-1 duty, ch CH-1 period, ..., ch0 duty, ch0 period.
REQ-014 st_clk=1 loads shadow <= sr for all channels and sets upd_pend for all channels in the same edge.
REQ-015 When sin_vld=1 and st_clk=1 in the same cycle, the shadow captures the pre-shift sr value.
REQ-016 Each channel has a counter cnt_k and active registers act_period_k and act_duty_k.
REQ-017 Period boundary for channel k: act_period_k=0, or cnt_k=act_period_k-1.
REQ-018 At a boundary: cnt_k <= 0; act_* <= shadow values; upd_pend[k] <= 0. Otherwise cnt_k <= cnt_k+1.
REQ-019 When st_clk=1 coincides with a boundary on channel k:
- act_* take the new sr fields directly (bypass).
- upd_pend[k] <= 0.
REQ-020 A second st_clk before the boundary overwrites the shadow; upd_pend stays 1; only the latest values apply.
REQ-021 pwm_out[k] <= (act_period_k != 0) && (cnt_k < act_duty_k). This gives one cycle of latency from the counter state.
REQ-022 Boundary cases:
- duty=0: constant low.
- duty >= period with period != 0: constant high.
- period=0: output low, counter held at 0, shadow applied every cycle.
- period=1: counter stays 0; output high iff duty >= 1.
REQ-023 All comparisons are unsigned, W bits wide; the counter never exceeds act_period-1, so it never wraps past 2^W-1.
REQ-024 Each channel's counter runs independently; channels are not phase-aligned except through reset.

Reset
REQ-025 rst_n=0 sampled on a clk edge SHALL clear sr, the shadows, act_*, the counters, pwm_out and upd_pend.
REQ-026 Immediately after reset release: sout=0 and pwm_out=0 on all channels; no pulse until a load is applied.
REQ-027 Reset asserted mid-frame or mid-period SHALL discard partial shift data and pending updates; no state survives.

Verification
REQ-028 CH=2, W=8:
- Stimulus: shift 32 bits (ch1 duty=8, period=16; ch0 duty=30, period=32), then st_clk.
- Response: ch0 high for 30 of every 32 cycles; ch1 high for 8 of every 16 cycles.
- upd_pend clears at each channel's first boundary.
REQ-029 Stimulus: running ch0 at 30/32, load 10/20 mid-period.
- Response: the current 32-cycle period completes unchanged, then 10/20 starts.
- No runt or truncated pulse.
REQ-030 Stimulus: ch0 at duty=0, duty=32/period=32, duty=255/period=5, and period=0.
- Response, respectively: always low; always high; always high; always low with upd_pend clearing next cycle.
REQ-031 Stimulus: daisy chain two instances, sin of the second = sout of the first; shift 64 bits; common st_clk.
- Response: the second instance receives the first 32 bits sent, the first instance the last 32.
REQ-032 Stimulus: st_clk exactly on the boundary cycle; and st_clk together with sin_vld=1.
- Response: bypass applies the new values the next period.
- The shadow holds the pre-shift sr.
REQ-033 Stimulus: rst_n=0 for one cycle mid-pulse, then release.
- Response: pwm_out=0 the next cycle; outputs stay low until a new load.

Source files
------------

// File: rtl/pwm_bank.sv
// pwm_bank: serially configured bank of independent PWM channels.
// Shadowed period/duty values are applied at each channel's boundary.
module pwm_bank #(
  parameter int CH = 2,
  parameter int W  = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sin,
  input  logic          sin_vld,
  input  logic          st_clk,
  output logic          sout,
  output logic [CH-1:0] pwm_out,
  output logic [CH-1:0] upd_pend
);

  localparam int N = CH * 2 * W;
  localparam logic [W-1:0] ONE = W'(1);

  logic [N-1:0] sr_q, sr_d;
  logic [N-1:0] shd_q, shd_d;

  always_comb begin
    sr_d = sr_q;
    if (sin_vld) sr_d = {sr_q[N-2:0], sin};
  end

  // the shadow takes the pre-shift register contents
  assign shd_d = st_clk ? sr_q : shd_q;
  assign sout  = sr_q[N-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_q  <= '0;
      shd_q <= '0;
    end else begin
      sr_q  <= sr_d;
      shd_q <= shd_d;
    end
  end

  for (genvar k = 0; k < CH; k++) begin : g_ch
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] per_q, per_d;
    logic [W-1:0] dty_q, dty_d;
    logic [W-1:0] src_per, src_dty;
    logic         pwm_q, pwm_d;
    logic         pend_q, pend_d;
    logic         bnd;

    // a load landing on the boundary bypasses the shadow
    assign src_per = st_clk ? sr_q[2*W*k +: W]
                            : shd_q[2*W*k +: W];
    assign src_dty = st_clk ? sr_q[2*W*k+W +: W]
                            : shd_q[2*W*k+W +: W];

    assign bnd = (per_q == '0) ||
                 (cnt_q == per_q - ONE);

    always_comb begin
      cnt_d  = cnt_q + ONE;
      per_d  = per_q;
      dty_d  = dty_q;
      pend_d = pend_q | st_clk;
      pwm_d  = (per_q != '0) && (cnt_q < dty_q);
      if (bnd) begin
        cnt_d  = '0;
        per_d  = src_per;
        dty_d  = src_dty;
        pend_d = 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cnt_q  <= '0;
        per_q  <= '0;
        dty_q  <= '0;
        pwm_q  <= 1'b0;
        pend_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        per_q  <= per_d;
        dty_q  <= dty_d;
        pwm_q  <= pwm_d;
        pend_q <= pend_d;
      end
    end

    assign pwm_out[k]  = pwm_q;
    assign upd_pend[k] = pend_q;
  end

endmodule

// File: tb/tb_pwm_bank.sv
// tb_pwm_bank: two daisy-chained pwm_bank instances checked against
// a cycle reference model, vector tables and corner sequences.
module tb_pwm_bank;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sin = 1'b0;
  logic vld = 1'b0;
  logic st = 1'b0;

  logic       a_sout, b_sout;
  logic [1:0] a_pwm, a_pend;
  logic [1:0] b_pwm, b_pend;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pwm_bank #(.CH(2), .W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .sin(sin),
    .sin_vld(vld), .st_clk(st), .sout(a_sout),
    .pwm_out(a_pwm), .upd_pend(a_pend)
  );

  pwm_bank #(.CH(2), .W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .sin(a_sout),
    .sin_vld(vld), .st_clk(st), .sout(b_sout),
    .pwm_out(b_pwm), .upd_pend(b_pend)
  );

  // reference model state, instance index 0 = u_a, 1 = u_b
  logic [31:0] m_sr[2];
  logic [31:0] m_sh[2];
  int          m_cnt[2][2];
  int          m_ap[2][2];
  int          m_ad[2][2];
  bit          m_pwm[2][2];
  bit          m_pend[2][2];

  typedef struct {
    logic [7:0] d1, p1, d0, p0;
    int         e1, e0;
  } vec_t;

  vec_t vt[8];

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d t=%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic int fld(logic [31:0] v, int k, int dty);
    logic [31:0] s;
    s = v >> (16 * k + 8 * dty);
    return int'(s & 32'hFF);
  endfunction

  function automatic logic [31:0] mk(logic [7:0] d1, logic [7:0] p1,
                                     logic [7:0] d0, logic [7:0] p0);
    return {d1, p1, d0, p0};
  endfunction

  task automatic model_update();
    logic [31:0] old[2];
    logic [31:0] src;
    bit          bin;
    old[0] = m_sr[0];
    old[1] = m_sr[1];
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_sr[i] = '0;
        m_sh[i] = '0;
        for (int k = 0; k < 2; k++) begin
          m_cnt[i][k] = 0; m_ap[i][k] = 0; m_ad[i][k] = 0;
          m_pwm[i][k] = 0; m_pend[i][k] = 0;
        end
      end else begin
        bin = (i == 0) ? sin : old[0][31];
        src = st ? old[i] : m_sh[i];
        for (int k = 0; k < 2; k++) begin
          m_pwm[i][k] = (m_ap[i][k] != 0) &&
                        (m_cnt[i][k] < m_ad[i][k]);
          if (m_ap[i][k] == 0 || m_cnt[i][k] == m_ap[i][k] - 1) begin
            m_cnt[i][k]  = 0;
            m_ap[i][k]   = fld(src, k, 0);
            m_ad[i][k]   = fld(src, k, 1);
            m_pend[i][k] = 0;
          end else begin
            m_cnt[i][k] = m_cnt[i][k] + 1;
            if (st) m_pend[i][k] = 1;
          end
        end
        if (st) m_sh[i] = old[i];
        if (vld) m_sr[i] = {old[i][30:0], bin};
      end
    end
  endtask

  task automatic compare();
    chk("a_sout", int'(a_sout), int'(m_sr[0][31]));
    chk("b_sout", int'(b_sout), int'(m_sr[1][31]));
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("a_pwm%0d", k), int'(a_pwm[k]), int'(m_pwm[0][k]));
      chk($sformatf("a_pend%0d", k), int'(a_pend[k]), int'(m_pend[0][k]));
      chk($sformatf("b_pwm%0d", k), int'(b_pwm[k]), int'(m_pwm[1][k]));
      chk($sformatf("b_pend%0d", k), int'(b_pend[k]), int'(m_pend[1][k]));
    end
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; st = 1'b0; vld = 1'b0; sin = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic shift(logic [31:0] f);
    for (int b = 31; b >= 0; b--) begin
      sin = f[b]; vld = 1'b1;
      step();
    end
    vld = 1'b0; sin = 1'b0;
  endtask

  task automatic load();
    st = 1'b1;
    step();
    st = 1'b0;
  endtask

  task automatic count(int n, output int a0, output int a1,
                       output int b0, output int b1);
    a0 = 0; a1 = 0; b0 = 0; b1 = 0;
    for (int i = 0; i < n; i++) begin
      step();
      a0 += int'(a_pwm[0]); a1 += int'(a_pwm[1]);
      b0 += int'(b_pwm[0]); b1 += int'(b_pwm[1]);
    end
  endtask

  initial begin
    int a0, a1, b0, b1, t;
    bit rec[150];
    int rlen[$];
    bit rval[$];
    logic [31:0] f;

    vt[0] = '{8'd8,   8'd16, 8'd30, 8'd32,  80, 150};
    vt[1] = '{8'd0,   8'd16, 8'd32, 8'd32,   0, 160};
    vt[2] = '{8'd255, 8'd5,  8'd0,  8'd0,  160,   0};
    vt[3] = '{8'd5,   8'd0,  8'd1,  8'd1,    0, 160};
    vt[4] = '{8'd0,   8'd1,  8'd3,  8'd10,   0,  48};
    vt[5] = '{8'd10,  8'd20, 8'd39, 8'd40,  80, 156};
    vt[6] = '{8'd1,   8'd2,  8'd80, 8'd160, 80,  80};
    vt[7] = '{8'd3,   8'd4,  8'd7,  8'd8,  120, 140};

    for (int i = 0; i < 2; i++) begin
      m_sr[i] = '0; m_sh[i] = '0;
      for (int k = 0; k < 2; k++) begin
        m_cnt[i][k] = 0; m_ap[i][k] = 0; m_ad[i][k] = 0;
        m_pwm[i][k] = 0; m_pend[i][k] = 0;
      end
    end

    // reset state
    do_reset();
    chk("rst_sout", int'(a_sout), 0);
    chk("rst_pwm", int'(a_pwm), 0);
    chk("rst_pend", int'(a_pend), 0);
    count(20, a0, a1, b0, b1);
    chk("idle_hi", a0 + a1 + b0 + b1, 0);

    // vector table: duty/period pairs incl. boundary cases
    for (int v = 0; v < 8; v++) begin
      do_reset();
      shift(mk(vt[v].d1, vt[v].p1, vt[v].d0, vt[v].p0));
      load();
      run(8);
      count(160, a0, a1, b0, b1);
      chk($sformatf("vec%0d_ch0", v), a0, vt[v].e0);
      chk($sformatf("vec%0d_ch1", v), a1, vt[v].e1);
    end

    // daisy chain: u_b gets the first 32 bits sent
    do_reset();
    shift(mk(8'd4, 8'd8, 8'd3, 8'd10));
    shift(mk(8'd8, 8'd16, 8'd30, 8'd32));
    load();
    run(8);
    count(160, a0, a1, b0, b1);
    chk("dc_a0", a0, 150);
    chk("dc_a1", a1, 80);
    chk("dc_b0", b0, 48);
    chk("dc_b1", b1, 80);

    // load together with a shift captures the pre-shift frame
    do_reset();
    shift(mk(8'd2, 8'd4, 8'd5, 8'd10));
    st = 1'b1; vld = 1'b1; sin = 1'b1;
    step();
    st = 1'b0; vld = 1'b0; sin = 1'b0;
    run(8);
    count(160, a0, a1, b0, b1);
    chk("sv_ch0", a0, 80);
    chk("sv_ch1", a1, 80);

    // load on the exact boundary cycle bypasses the shadow
    do_reset();
    shift(mk(8'd8, 8'd16, 8'd30, 8'd32));
    load();
    run(40);
    shift(mk(8'd8, 8'd16, 8'd10, 8'd20));
    t = 0;
    while (t < 64 && m_cnt[0][0] != m_ap[0][0] - 1) begin
      step();
      t++;
    end
    chk("byp_align", int'(m_cnt[0][0] == m_ap[0][0] - 1), 1);
    load();
    chk("byp_pend0", int'(a_pend[0]), 0);
    run(4);
    count(160, a0, a1, b0, b1);
    chk("byp_ch0", a0, 80);
    chk("byp_ch1", a1, 80);

    // mid-period load: old period completes, no runt pulse
    do_reset();
    shift(mk(8'd8, 8'd16, 8'd30, 8'd32));
    load();
    run(40);
    shift(mk(8'd8, 8'd16, 8'd10, 8'd20));
    load();
    chk("mid_pend0", int'(a_pend[0]), 1);
    for (int i = 0; i < 150; i++) begin
      step();
      rec[i] = a_pwm[0];
    end
    rlen.delete();
    rval.delete();
    rval.push_back(rec[0]);
    rlen.push_back(1);
    for (int i = 1; i < 150; i++) begin
      if (rec[i] == rval[rval.size()-1]) begin
        rlen[rlen.size()-1] = rlen[rlen.size()-1] + 1;
      end else begin
        rval.push_back(rec[i]);
        rlen.push_back(1);
      end
    end
    chk("mid_first_hi", int'(rval[0]), 1);
    chk("mid_runs", int'(rlen.size() >= 6), 1);
    if (rlen.size() >= 6) begin
      chk("mid_tail_lo", rlen[1], 2);
      for (int r = 2; r < rlen.size() - 1; r++)
        chk($sformatf("mid_run%0d", r), rlen[r], 10);
    end
    chk("mid_pend_done", int'(a_pend[0]), 0);

    // reset mid-pulse
    t = 0;
    while (t < 64 && a_pwm[0] != 1'b1) begin
      step();
      t++;
    end
    chk("rp_high", int'(a_pwm[0]), 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rp_pwm", int'(a_pwm), 0);
    chk("rp_pend", int'(a_pend), 0);
    chk("rp_sout", int'(a_sout), 0);
    count(50, a0, a1, b0, b1);
    chk("rp_quiet", a0 + a1 + b0 + b1, 0);

    // randomized frames, stalls, loads and rare resets
    do_reset();
    for (int it = 0; it < 40; it++) begin
      f = mk(8'($urandom_range(0, 14)), 8'($urandom_range(0, 12)),
             8'($urandom_range(0, 14)), 8'($urandom_range(0, 12)));
      for (int b = 31; b >= 0; ) begin
        sin = f[b];
        vld = ($urandom_range(0, 3) != 0);
        st = ($urandom_range(0, 40) == 0);
        rst_n = ($urandom_range(0, 300) != 0);
        step();
        if (vld) b--;
      end
      vld = 1'b0; st = 1'b0; rst_n = 1'b1;
      load();
      for (int i = 0; i < int'($urandom_range(0, 40)); i++) begin
        st = ($urandom_range(0, 15) == 0);
        vld = ($urandom_range(0, 7) == 0);
        sin = 1'($urandom);
        step();
      end
      st = 1'b0; vld = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
